// File: rtl/row_cache_lru_pkg.sv
// Shared types for the fully-associative DRAM row cache.
package row_cache_lru_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL,
        ACCESS,
        FLUSH_SCAN,
        FLUSH_WB
    } state_t;

    typedef enum logic {
        READ,
        WRITE
    } op_t;

endpackage

// File: rtl/row_cache_lru_if.sv
// Request/response and backing-store handshake bundle for the row cache.
interface row_cache_lru_if #(
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17
);
    logic                 RD;
    logic                 WR;
    logic                 flush;
    logic [ADDRWIDTH-1:0] RowId;
    logic                 sync;
    logic [CHWIDTH-1:0]   cRowId;
    logic                 hit;
    logic                 done;
    logic                 hold;
    logic                 wbReq;
    logic [ADDRWIDTH-1:0] wbRowId;
    logic                 fillReq;
    logic [ADDRWIDTH-1:0] fillRowId;
    logic                 flushDone;

    modport master (
        output RD, WR, flush, RowId, sync,
        input  cRowId, hit, done, hold, wbReq, wbRowId, fillReq, fillRowId, flushDone
    );

    modport slave (
        input  RD, WR, flush, RowId, sync,
        output cRowId, hit, done, hold, wbReq, wbRowId, fillReq, fillRowId, flushDone
    );
endinterface

// File: rtl/row_cache_lru_age_array.sv
// True-LRU age table: ages stay a permutation of 0..CHROWS-1; picks the replacement victim.
module lru_age_array #(
    parameter int CHWIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [(1<<CHWIDTH)-1:0]   valid,
    input  logic                      en,
    input  logic [CHWIDTH-1:0]        idx,
    output logic [CHWIDTH-1:0]        victim
);
    localparam int CHROWS = 1 << CHWIDTH;

    logic [CHWIDTH-1:0] age [CHROWS];
    logic               found;

    // Touching a slot makes it youngest; only slots younger than it age by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHROWS; i++) age[i] <= CHWIDTH'(i);
        end else if (en) begin
            for (int i = 0; i < CHROWS; i++) begin
                if (CHWIDTH'(i) == idx)
                    age[i] <= '0;
                else if (age[i] < age[idx])
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int i = 0; i < CHROWS; i++) begin
            if (!valid[i] && !found) begin
                victim = CHWIDTH'(i);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 0; i < CHROWS; i++) begin
                if (age[i] == '1) victim = CHWIDTH'(i);
            end
        end
    end
endmodule

// File: rtl/row_cache_lru.sv
// Fully-associative DRAM row cache with true-LRU replacement, dirty writeback and flush.
module row_cache_lru
    import row_cache_lru_pkg::*;
#(
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17
) (
    input  logic            clk,
    input  logic            rst,
    row_cache_lru_if.slave  bus
);
    localparam int CHROWS = 1 << CHWIDTH;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [ADDRWIDTH-1:0] rowaddr;
    } slot_t;

    slot_t                slots [CHROWS];
    state_t               state, next;
    op_t                  op;
    logic [ADDRWIDTH-1:0] row;
    logic [CHWIDTH-1:0]   slot;
    logic [CHWIDTH-1:0]   ptr;
    logic [CHWIDTH-1:0]   victim;
    logic [CHWIDTH-1:0]   hit_idx;
    logic                 lookup_hit;
    logic                 hit_r;
    logic                 flush_done_r;
    logic [CHROWS-1:0]    valid_vec;

    lru_age_array #(.CHWIDTH(CHWIDTH)) u_age (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid_vec),
        .en     (state == ACCESS),
        .idx    (slot),
        .victim (victim)
    );

    always_comb begin
        valid_vec  = '0;
        lookup_hit = 1'b0;
        hit_idx    = '0;
        for (int i = 0; i < CHROWS; i++) begin
            valid_vec[i] = slots[i].valid;
            if (slots[i].valid && slots[i].rowaddr == row) begin
                lookup_hit = 1'b1;
                hit_idx    = CHWIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:       if (bus.flush) next = FLUSH_SCAN;
                        else if (bus.WR || bus.RD) next = LOOKUP;
            LOOKUP:     if (lookup_hit) next = ACCESS;
                        else if (slots[victim].valid && slots[victim].dirty) next = WB;
                        else next = FILL;
            WB:         if (bus.sync) next = FILL;
            FILL:       if (bus.sync) next = ACCESS;
            ACCESS:     next = IDLE;
            FLUSH_SCAN: if (slots[ptr].valid && slots[ptr].dirty) next = FLUSH_WB;
                        else if (ptr == '1) next = IDLE;
            FLUSH_WB:   if (bus.sync) next = FLUSH_SCAN;
            default:    next = IDLE;
        endcase
    end

    // Datapath: request latch, slot table, flush pointer. A flushed slot is re-examined once clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op           <= READ;
            row          <= '0;
            slot         <= '0;
            ptr          <= '0;
            hit_r        <= 1'b0;
            flush_done_r <= 1'b0;
            for (int i = 0; i < CHROWS; i++) slots[i] <= '0;
        end else begin
            flush_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        ptr <= '0;
                    end else if (bus.WR) begin
                        op  <= WRITE;
                        row <= bus.RowId;
                    end else if (bus.RD) begin
                        op  <= READ;
                        row <= bus.RowId;
                    end
                end
                LOOKUP: begin
                    slot  <= lookup_hit ? hit_idx : victim;
                    hit_r <= lookup_hit;
                end
                WB: if (bus.sync) begin
                    slots[slot].valid <= 1'b0;
                    slots[slot].dirty <= 1'b0;
                end
                FILL: if (bus.sync) begin
                    slots[slot].valid   <= 1'b1;
                    slots[slot].dirty   <= 1'b0;
                    slots[slot].rowaddr <= row;
                end
                ACCESS: if (op == WRITE) slots[slot].dirty <= 1'b1;
                FLUSH_SCAN: begin
                    if (!(slots[ptr].valid && slots[ptr].dirty)) begin
                        if (ptr == '1) flush_done_r <= 1'b1;
                        else           ptr <= ptr + 1'b1;
                    end
                end
                FLUSH_WB: if (bus.sync) slots[ptr].dirty <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.done      = (state == ACCESS);
        bus.hold      = (state == WB) || (state == FILL) || (state == FLUSH_WB);
        bus.wbReq     = (state == WB) || (state == FLUSH_WB);
        bus.fillReq   = (state == FILL);
        bus.fillRowId = row;
        bus.cRowId    = slot;
        bus.hit       = hit_r;
        bus.flushDone = flush_done_r;
        bus.wbRowId   = '0;
        if (state == WB)            bus.wbRowId = slots[slot].rowaddr;
        else if (state == FLUSH_WB) bus.wbRowId = slots[ptr].rowaddr;
    end
endmodule

// File: tb/tb_row_cache_lru.sv
// Directed bench for row_cache_lru with four slots: fills, hits, LRU eviction, writeback, flush, reset.
module tb_row_cache_lru;
    localparam int CW = 2;
    localparam int AW = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    row_cache_lru_if #(.CHWIDTH(CW), .ADDRWIDTH(AW)) bus ();

    row_cache_lru #(.CHWIDTH(CW), .ADDRWIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one IDLE cycle; returns just after the accepting edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic fl, input logic [AW-1:0] r);
        @(posedge clk); #1;
        bus.RD = rd; bus.WR = wr; bus.flush = fl; bus.RowId = r;
        @(posedge clk); #1;
        bus.RD = 1'b0; bus.WR = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic pulseSync(input int delay);
        repeat (delay) @(posedge clk);
        #1 bus.sync = 1'b1;
        @(posedge clk); #1;
        bus.sync = 1'b0;
    endtask

    task automatic waitSignal(input int sel, input string tag);
        logic s;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            s = (sel == 0) ? bus.wbReq : bus.flushDone;
            n++;
        end while (!s && n < 20);
        checkOutput(tag, {31'd0, s}, 32'd1);
    endtask

    task automatic accessMiss(input logic rd, input logic wr, input logic [AW-1:0] r,
                              input int exp_slot, input logic exp_wb, input logic [AW-1:0] exp_wb_row,
                              input int sync_delay);
        applyStimulus(rd, wr, 1'b0, r);
        @(negedge clk);
        @(negedge clk);
        checkOutput("miss_wbReq", {31'd0, bus.wbReq}, {31'd0, exp_wb});
        if (exp_wb) begin
            checkOutput("wbRowId", 32'(bus.wbRowId), 32'(exp_wb_row));
            checkOutput("wb_hold", {31'd0, bus.hold}, 32'd1);
            pulseSync(0);
            @(negedge clk);
        end
        checkOutput("fillReq", {31'd0, bus.fillReq}, 32'd1);
        checkOutput("fillRowId", 32'(bus.fillRowId), 32'(r));
        checkOutput("fill_hold", {31'd0, bus.hold}, 32'd1);
        pulseSync(sync_delay);
        @(negedge clk);
        checkOutput("miss_done", {31'd0, bus.done}, 32'd1);
        checkOutput("miss_hit", {31'd0, bus.hit}, 32'd0);
        checkOutput("miss_cRowId", 32'(bus.cRowId), 32'(exp_slot));
        checkOutput("miss_hold", {31'd0, bus.hold}, 32'd0);
    endtask

    task automatic accessHit(input logic rd, input logic wr, input logic [AW-1:0] r, input int exp_slot);
        applyStimulus(rd, wr, 1'b0, r);
        @(negedge clk);
        checkOutput("hit_early_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        checkOutput("hit_done", {31'd0, bus.done}, 32'd1);
        checkOutput("hit_hit", {31'd0, bus.hit}, 32'd1);
        checkOutput("hit_cRowId", 32'(bus.cRowId), 32'(exp_slot));
        checkOutput("hit_fillReq", {31'd0, bus.fillReq}, 32'd0);
        checkOutput("hit_wbReq", {31'd0, bus.wbReq}, 32'd0);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.RD = 1'b0; bus.WR = 1'b0; bus.flush = 1'b0; bus.sync = 1'b0; bus.RowId = '0;
        $display("[TB] start");

        repeat (2) @(negedge clk);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_hold", {31'd0, bus.hold}, 32'd0);
        checkOutput("rst_wbReq", {31'd0, bus.wbReq}, 32'd0);
        checkOutput("rst_fillReq", {31'd0, bus.fillReq}, 32'd0);
        checkOutput("rst_flushDone", {31'd0, bus.flushDone}, 32'd0);
        checkOutput("rst_cRowId", 32'(bus.cRowId), 32'd0);
        checkOutput("rst_fillRowId", 32'(bus.fillRowId), 32'd0);
        rst = 1'b0;

        // Cold miss then hit on the same row.
        accessMiss(1'b1, 1'b0, 17'h00010, 0, 1'b0, '0, 3);
        accessHit(1'b1, 1'b0, 17'h00010, 0);

        // Fill every slot, refresh row 1, then replace the least recently used.
        resetPulse();
        accessMiss(1'b1, 1'b0, 17'd1, 0, 1'b0, '0, 0);
        accessMiss(1'b1, 1'b0, 17'd2, 1, 1'b0, '0, 0);
        accessMiss(1'b1, 1'b0, 17'd3, 2, 1'b0, '0, 0);
        accessMiss(1'b1, 1'b0, 17'd4, 3, 1'b0, '0, 0);
        accessHit(1'b1, 1'b0, 17'd1, 0);
        accessMiss(1'b1, 1'b0, 17'd5, 1, 1'b0, '0, 0);

        // Dirty row 7 lands in slot 2; age it out and expect a writeback.
        accessMiss(1'b0, 1'b1, 17'd7, 2, 1'b0, '0, 0);
        accessHit(1'b1, 1'b0, 17'd4, 3);
        accessHit(1'b1, 1'b0, 17'd1, 0);
        accessHit(1'b1, 1'b0, 17'd5, 1);
        accessMiss(1'b1, 1'b0, 17'd8, 2, 1'b1, 17'd7, 0);

        // Dirty slots 2 (row 8) and 0 (row 1), then flush in slot order.
        accessHit(1'b0, 1'b1, 17'd8, 2);
        accessHit(1'b0, 1'b1, 17'd1, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        waitSignal(0, "flush_wb0");
        checkOutput("flush_wbRowId0", 32'(bus.wbRowId), 32'd1);
        pulseSync(0);
        @(negedge clk);
        checkOutput("flush_wb_cleared", {31'd0, bus.wbReq}, 32'd0);
        waitSignal(0, "flush_wb2");
        checkOutput("flush_wbRowId2", 32'(bus.wbRowId), 32'd8);
        pulseSync(0);
        waitSignal(1, "flushDone");
        @(negedge clk);
        checkOutput("flushDone_pulse", {31'd0, bus.flushDone}, 32'd0);

        // Flushed slot 2 is evicted without a writeback.
        accessMiss(1'b1, 1'b0, 17'd9, 3, 1'b0, '0, 0);
        accessMiss(1'b1, 1'b0, 17'd10, 1, 1'b0, '0, 0);
        accessMiss(1'b1, 1'b0, 17'd11, 2, 1'b0, '0, 0);

        // Reset in the middle of a fill.
        applyStimulus(1'b1, 1'b0, 1'b0, 17'd12);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_fillReq", {31'd0, bus.fillReq}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_fillReq", {31'd0, bus.fillReq}, 32'd0);
        checkOutput("async_hold", {31'd0, bus.hold}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        accessMiss(1'b1, 1'b0, 17'd10, 0, 1'b0, '0, 0);

        // RD and WR together take the write path; its eviction writes back.
        accessMiss(1'b1, 1'b1, 17'd13, 1, 1'b0, '0, 0);
        accessMiss(1'b1, 1'b0, 17'd14, 2, 1'b0, '0, 0);
        accessMiss(1'b1, 1'b0, 17'd15, 3, 1'b0, '0, 0);
        accessHit(1'b1, 1'b0, 17'd10, 0);
        accessMiss(1'b1, 1'b0, 17'd16, 1, 1'b1, 17'd13, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
